vram_host_writer: RTL and testbench
===================================

// Module: vram_host_writer
// PURPOSE
//  Host-side write port for the video block. Accepts a byte stream over a valid/ready
//  handshake and turns it into writes to the palette RAM (pwrite_enable/pwaddr/pin)
//  and the sprite attribute RAM (wspno/wsx/wsy/wsp).
//  Palette writes commit immediately. Sprite writes are held until vertical blank so
//  the line renderer never sees a torn (x,y) pair.
// PARAMETERS
//  NB       7    sprite index width (2**NB sprites)
//  VB_LINE  720  sprite commits allowed only while py > VB_LINE
// PORTS
//  clk          in   1    video clock
//  rst          in   1    asynchronous reset, active-low
//  py           in   10   current scan line
//  host_valid   in   1    host byte valid
//  host_ready   out  1    block can accept a byte this cycle
//  host_sel     in   2    0=palette data, 1=sprite data, 2=address set, 3=reserved
//  host_data    in   8    byte payload
//  pwrite_enable out 1    palette RAM write strobe
//  pwaddr       out  6    palette RAM byte address {idx,phase}
//  pin          out  8    palette RAM write data
//  wspno        out  NB   sprite RAM write index
//  wsx, wsy     out  8    sprite RAM write data
//  wsp          out  1    sprite RAM write strobe
//  busy         out  1    sprite entry pending commit (state==SPR_WAIT)
// BEHAVIOUR
//  - Transfer: a byte is accepted at a posedge where host_valid && host_ready.
//    host_ready = (state != SPR_WAIT); it is combinational from state.
//  - Reset (rst=0, async): all outputs 0, pal_idx=0, pal_ph=0, spr_idx=0, state=IDLE.
//    A pending sprite entry is discarded. host_ready=1 while in reset.
//  - sel=2 (address set):
//    - data[7]=0: pal_idx<=data[3:0], pal_ph<=0.
//    - data[7]=1: spr_idx<=data[NB-1:0], state<=IDLE (drops a half-entered x byte).
//  - sel=0 (palette), one write per byte:
//    - Next cycle: pwrite_enable=1 for 1 cycle, pwaddr={pal_idx,pal_ph}, pin=data.
//    - Byte 0 = {R,G} nibbles; byte 1 low nibble = B.
//    - pal_ph toggles each byte. When pal_ph was 1, pal_idx increments mod 16 (15->0).
//    - Latency is 1 clock. Back-to-back bytes give back-to-back strobes.
//  - sel=1 (sprite), state machine IDLE -> SPR_X -> SPR_WAIT -> IDLE:
//    - IDLE: accepted byte -> x_lat, go to SPR_X.
//    - SPR_X: accepted byte -> y_lat, go to SPR_WAIT (host_ready drops next cycle).
//    - SPR_WAIT, when py > VB_LINE:
//      - wsp=1 for exactly 1 cycle with wspno=spr_idx, wsx=x_lat, wsy=y_lat.
//      - Same edge: spr_idx increments mod 2**NB; state->IDLE.
//    - SPR_WAIT otherwise: hold; no strobe; host_ready=0.
//    - wsx/wsy/wspno keep their last values when wsp=0.
//  - Palette and sprite byte phases are independent. Palette bytes are accepted in
//    IDLE/SPR_X without disturbing the sprite state.
//  - sel=3: byte is accepted (handshake completes) and ignored; no state change.
//  - py moving from blank back to 0 while in SPR_WAIT: no commit; wait for next blank.
//  - Entering SPR_WAIT on a cycle where py > VB_LINE already holds: commit on the
//    following cycle.
//  - pwrite_enable and wsp may assert in the same cycle; the targets are separate RAMs.
// TESTING
//  1 Reset: rst=0 mid-SPR_WAIT -> wsp never pulses; after release host_ready=1,
//    spr_idx=0, all outputs 0.
//  2 Palette: sel2 0x03, then sel0 bytes 0xA5,0x0C,0x11 ->
//    strobes (pwaddr,pin) = (6,A5),(7,0C),(8,11), each 1 clk after acceptance.
//  3 Palette wrap: sel2 0x0F, then 4 palette bytes -> pwaddr 30,31,0,1.
//  4 Sprite hold: py=100, sel2 0x85, sel1 0x40,0x22 ->
//    - host_ready=0, busy=1, no wsp while py<=720;
//    - py=721 -> one wsp with wspno=5, wsx=40, wsy=22; then spr_idx=6, host_ready=1.
//  5 Sprite wrap and interleave:
//    - sel2 0xFF, sel1 0x10, sel0 0x77, sel1 0x20, in blank ->
//      pwrite 0x77 at pwaddr {pal_idx,pal_ph} (unchanged by the sprite bytes), then
//      wsp with wspno=127, wsx=10, wsy=20; spr_idx wraps to 0.
//    - sel3 bytes in any state -> accepted, no strobes.
//  6 Address mid-pair: sel1 0x33, then sel2 0x82, then sel1 0x44,0x55, blank ->
//    one commit: wspno=2, wsx=44, wsy=55.

Source files
------------

// File: rtl/vram_host_writer.sv
// vram_host_writer
// Host byte-stream write port for the video block. Palette bytes are written
// straight through to the palette RAM one clock after acceptance; sprite (x,y)
// pairs are collected and held until vertical blank so the line renderer never
// observes a half-updated sprite entry.
module vram_host_writer #(
   parameter int NB      = 7,
   parameter int VB_LINE = 720
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [9:0]    py,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic [1:0]    host_sel,
   input  logic [7:0]    host_data,
   output logic          pwrite_enable,
   output logic [5:0]    pwaddr,
   output logic [7:0]    pin,
   output logic [NB-1:0] wspno,
   output logic [7:0]    wsx,
   output logic [7:0]    wsy,
   output logic          wsp,
   output logic          busy
);

   localparam logic [9:0]    VB_LINE_W = 10'(VB_LINE);
   localparam logic [NB-1:0] SPR_ONE   = {{(NB-1){1'b0}}, 1'b1};

   localparam logic [1:0] SEL_PAL  = 2'd0;
   localparam logic [1:0] SEL_SPR  = 2'd1;
   localparam logic [1:0] SEL_ADDR = 2'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPR_X    = 2'd1,
      SPR_WAIT = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    pal_idx;
   logic          pal_ph;
   logic [NB-1:0] spr_idx;
   logic [7:0]    x_lat;
   logic [7:0]    y_lat;
   logic          xfer_p0;
   logic          in_blank;

   // The only back-pressure is a complete sprite entry waiting for blank.
   assign host_ready = (state != SPR_WAIT);
   assign busy       = (state == SPR_WAIT);
   assign xfer_p0    = host_valid && host_ready;
   assign in_blank   = (py > VB_LINE_W);

   // Sprite coordinate latches: pure data, no reset needed since a commit is
   // only reachable after both bytes have been written.
   always_ff @(posedge clk) begin
      if (xfer_p0 && host_sel == SEL_SPR) begin
         if (state == IDLE) begin
            x_lat <= host_data;
         end else begin
            y_lat <= host_data;
         end
      end
   end

   // Control FSM plus registered palette and sprite RAM write ports.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         pal_idx       <= 4'd0;
         pal_ph        <= 1'b0;
         spr_idx       <= '0;
         pwrite_enable <= 1'b0;
         pwaddr        <= 6'd0;
         pin           <= 8'd0;
         wsp           <= 1'b0;
         wspno         <= '0;
         wsx           <= 8'd0;
         wsy           <= 8'd0;
      end else begin
         // Strobes are single-cycle unless re-armed below.
         pwrite_enable <= 1'b0;
         wsp           <= 1'b0;

         if (state == SPR_WAIT) begin
            // No bytes are accepted here; commit the pair once in blank.
            if (in_blank) begin
               wsp     <= 1'b1;
               wspno   <= spr_idx;
               wsx     <= x_lat;
               wsy     <= y_lat;
               spr_idx <= spr_idx + SPR_ONE;
               state   <= IDLE;
            end
         end else if (xfer_p0) begin
            unique case (host_sel)
               SEL_PAL: begin
                  pwrite_enable <= 1'b1;
                  pwaddr        <= {1'b0, pal_idx, pal_ph};
                  pin           <= host_data;
                  pal_ph        <= ~pal_ph;
                  if (pal_ph) begin
                     pal_idx <= pal_idx + 4'd1;
                  end
               end
               SEL_SPR: begin
                  state <= (state == IDLE) ? SPR_X : SPR_WAIT;
               end
               SEL_ADDR: begin
                  if (host_data[7]) begin
                     // Re-targeting the sprite index abandons any half pair.
                     spr_idx <= host_data[NB-1:0];
                     state   <= IDLE;
                  end else begin
                     pal_idx <= host_data[3:0];
                     pal_ph  <= 1'b0;
                  end
               end
               default: begin
                  // Reserved selector: byte is consumed and ignored.
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vram_host_writer.sv
// Self-checking bench for vram_host_writer: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-level reference model.
module tb_vram_host_writer;

   localparam int NB      = 7;
   localparam int VB_LINE = 720;

   logic          clk;
   logic          rst;
   logic [9:0]    py;
   logic          host_valid;
   logic          host_ready;
   logic [1:0]    host_sel;
   logic [7:0]    host_data;
   logic          pwrite_enable;
   logic [5:0]    pwaddr;
   logic [7:0]    pin;
   logic [NB-1:0] wspno;
   logic [7:0]    wsx;
   logic [7:0]    wsy;
   logic          wsp;
   logic          busy;

   int checks = 0;
   int errors = 0;

   vram_host_writer #(.NB(NB), .VB_LINE(VB_LINE)) dut (
      .clk(clk), .rst(rst), .py(py),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_sel(host_sel), .host_data(host_data),
      .pwrite_enable(pwrite_enable), .pwaddr(pwaddr), .pin(pin),
      .wspno(wspno), .wsx(wsx), .wsy(wsy), .wsp(wsp), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Palette position is one linear 5-bit byte counter (16 entries x 2 bytes);
   // a sprite entry is just a count of bytes collected so far (0..2).
   logic [4:0]    m_pal;
   logic [NB-1:0] m_spr;
   int            m_cnt;
   logic [7:0]    m_x, m_y;
   logic          e_pwe, e_wsp;
   logic [5:0]    e_pwaddr;
   logic [7:0]    e_pin, e_wsx, e_wsy;
   logic [NB-1:0] e_wspno;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pal <= 0; m_spr <= 0; m_cnt <= 0; m_x <= 0; m_y <= 0;
         e_pwe <= 0; e_pwaddr <= 0; e_pin <= 0;
         e_wsp <= 0; e_wspno <= 0; e_wsx <= 0; e_wsy <= 0;
      end else begin
         e_pwe <= 0;
         e_wsp <= 0;
         if (m_cnt == 2) begin
            if (int'(py) > VB_LINE) begin
               e_wsp <= 1; e_wspno <= m_spr; e_wsx <= m_x; e_wsy <= m_y;
               m_spr <= m_spr + 1'b1;
               m_cnt <= 0;
            end
         end else if (host_valid) begin
            case (host_sel)
               2'd0: begin
                  e_pwe <= 1; e_pwaddr <= {1'b0, m_pal}; e_pin <= host_data;
                  m_pal <= m_pal + 1'b1;
               end
               2'd1: begin
                  if (m_cnt == 0) begin m_x <= host_data; m_cnt <= 1; end
                  else begin m_y <= host_data; m_cnt <= 2; end
               end
               2'd2: begin
                  if (host_data[7]) begin m_spr <= host_data[NB-1:0]; m_cnt <= 0; end
                  else m_pal <= {host_data[3:0], 1'b0};
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- compare + event capture ----------------
   logic [13:0] pq[$];
   logic [22:0] sq[$];

   always @(negedge clk) begin
      chk("host_ready", host_ready, m_cnt != 2);
      chk("busy", busy, m_cnt == 2);
      chk("pwrite_enable", pwrite_enable, e_pwe);
      chk("pwaddr", pwaddr, e_pwaddr);
      chk("pin", pin, e_pin);
      chk("wsp", wsp, e_wsp);
      chk("wspno", wspno, e_wspno);
      chk("wsx", wsx, e_wsx);
      chk("wsy", wsy, e_wsy);
      if (pwrite_enable) pq.push_back({pwaddr, pin});
      if (wsp) sq.push_back({wspno, wsx, wsy});
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [1:0] sel, input logic [7:0] data);
      int n;
      host_valid = 1'b1;
      host_sel   = sel;
      host_data  = data;
      n = 0;
      @(negedge clk);
      while (!host_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!host_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: host_ready stuck at 0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      host_valid = 1'b0;
   endtask

   task automatic waitc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clrq();
      pq.delete();
      sq.delete();
   endtask

   task automatic chk_pal(input string name, input int i, input logic [5:0] a, input logic [7:0] d);
      if (pq.size() > i) chk(name, pq[i], {a, d});
      else chk({name, "_missing"}, pq.size(), i + 1);
   endtask

   task automatic chk_spr(input string name, input int i, input logic [NB-1:0] no,
                          input logic [7:0] x, input logic [7:0] y);
      if (sq.size() > i) chk(name, sq[i], {no, x, y});
      else chk({name, "_missing"}, sq.size(), i + 1);
   endtask

   initial begin
      rst = 1'b0; py = 10'd0; host_valid = 1'b0; host_sel = 2'd0; host_data = 8'd0;
      waitc(3);
      chk("rst_ready", host_ready, 1);
      chk("rst_outs", {pwrite_enable, pwaddr, pin, wspno, wsx, wsy, wsp, busy}, 0);
      rst = 1'b1;
      waitc(2);

      // Reset while a sprite entry is pending: it must be discarded.
      clrq();
      py = 10'd100;
      send(2'd2, 8'h8A);
      send(2'd1, 8'h11);
      send(2'd1, 8'h22);
      waitc(2);
      chk("t1_busy", busy, 1);
      rst = 1'b0;
      py = 10'd800;
      waitc(3);
      chk("t1_ready_in_rst", host_ready, 1);
      chk("t1_outs_in_rst", {pwrite_enable, pwaddr, pin, wspno, wsx, wsy, wsp, busy}, 0);
      rst = 1'b1;
      waitc(3);
      chk("t1_no_wsp", sq.size(), 0);
      send(2'd1, 8'h01);
      send(2'd1, 8'h02);
      waitc(3);
      chk("t1_nspr", sq.size(), 1);
      chk_spr("t1_idx0", 0, 7'd0, 8'h01, 8'h02);

      // Palette back-to-back writes.
      clrq();
      py = 10'd100;
      send(2'd2, 8'h03);
      send(2'd0, 8'hA5);
      send(2'd0, 8'h0C);
      send(2'd0, 8'h11);
      waitc(2);
      chk("t2_n", pq.size(), 3);
      chk_pal("t2_0", 0, 6'd6, 8'hA5);
      chk_pal("t2_1", 1, 6'd7, 8'h0C);
      chk_pal("t2_2", 2, 6'd8, 8'h11);

      // Palette index wrap 15 -> 0.
      clrq();
      send(2'd2, 8'h0F);
      for (int i = 0; i < 4; i++) send(2'd0, 8'(8'h50 + i));
      waitc(2);
      chk_pal("t3_0", 0, 6'd30, 8'h50);
      chk_pal("t3_1", 1, 6'd31, 8'h51);
      chk_pal("t3_2", 2, 6'd0, 8'h52);
      chk_pal("t3_3", 3, 6'd1, 8'h53);

      // Sprite held until blank.
      clrq();
      py = 10'd100;
      send(2'd2, 8'h85);
      send(2'd1, 8'h40);
      send(2'd1, 8'h22);
      waitc(4);
      py = 10'd720;
      waitc(3);
      chk("t4_ready", host_ready, 0);
      chk("t4_busy", busy, 1);
      chk("t4_hold", sq.size(), 0);
      py = 10'd721;
      waitc(3);
      chk("t4_n", sq.size(), 1);
      chk_spr("t4_c", 0, 7'd5, 8'h40, 8'h22);
      chk("t4_ready_after", host_ready, 1);
      send(2'd1, 8'h0A);
      send(2'd1, 8'h0B);
      waitc(3);
      chk_spr("t4_next", 1, 7'd6, 8'h0A, 8'h0B);

      // Sprite index wrap with an interleaved palette byte; reserved bytes.
      clrq();
      py = 10'd900;
      send(2'd2, 8'h04);
      send(2'd2, 8'hFF);
      send(2'd1, 8'h10);
      send(2'd0, 8'h77);
      send(2'd1, 8'h20);
      waitc(3);
      chk("t5_np", pq.size(), 1);
      chk_pal("t5_pal", 0, 6'd8, 8'h77);
      chk("t5_ns", sq.size(), 1);
      chk_spr("t5_spr", 0, 7'd127, 8'h10, 8'h20);
      send(2'd3, 8'hEE);
      send(2'd1, 8'h30);
      send(2'd3, 8'hDD);
      send(2'd1, 8'h31);
      waitc(3);
      chk("t5_np3", pq.size(), 1);
      chk_spr("t5_wrap", 1, 7'd0, 8'h30, 8'h31);

      // Sprite address reset mid-pair.
      clrq();
      py = 10'd100;
      send(2'd1, 8'h33);
      send(2'd2, 8'h82);
      send(2'd1, 8'h44);
      send(2'd1, 8'h55);
      py = 10'd1000;
      waitc(3);
      chk("t6_n", sq.size(), 1);
      chk_spr("t6_c", 0, 7'd2, 8'h44, 8'h55);

      // Randomized traffic with blank toggling and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         host_valid = ($urandom_range(3) != 0);
         host_sel   = 2'($urandom_range(3));
         host_data  = 8'($urandom);
         if ($urandom_range(15) == 0) begin
            case ($urandom_range(3))
               0: py = 10'(VB_LINE);
               1: py = 10'(VB_LINE + 1);
               2: py = 10'($urandom_range(VB_LINE));
               default: py = 10'($urandom_range(1023, VB_LINE + 1));
            endcase
         end
         if ($urandom_range(499) == 0) rst = 1'b0;
         else rst = 1'b1;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      host_valid = 1'b0;
      waitc(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
